// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage registers: stage occupancy states and control bit positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'b00,
    PS_ONE   = 2'b01,
    PS_FULL  = 2'b10
  } pipe_state_e;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMWRITE = 1;
  localparam int unsigned CTRL_MEMREAD  = 2;
  localparam int unsigned CTRL_MEMTOREG = 3;
  localparam int unsigned CTRL_ALUSRC   = 4;
  localparam int unsigned CTRL_BRANCH   = 5;
  localparam int unsigned CTRL_JUMP     = 6;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with synchronous clear; holds at all-ones instead of wrapping.
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and a 2-entry skid buffer.
// Performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipe_state_e       r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  // Payload registers are deliberately left out of the reset/flush branch.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_state     <= PS_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_ctrl <= CTRL_RST;
      r_skid_ctrl <= CTRL_RST;
    end else begin
      unique case (r_state)
        PS_EMPTY: begin
          if (in_valid) begin
            r_state     <= PS_ONE;
            r_out_valid <= 1'b1;
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end
        end
        PS_ONE: begin
          if (in_valid && out_ready) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (in_valid) begin
            r_state     <= PS_FULL;
            r_in_ready  <= 1'b0;
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
          end else if (out_ready) begin
            r_state     <= PS_EMPTY;
            r_out_valid <= 1'b0;
            r_main_ctrl <= CTRL_RST;
          end
        end
        PS_FULL: begin
          if (out_ready) begin
            r_state     <= PS_ONE;
            r_in_ready  <= 1'b1;
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_skid_ctrl <= CTRL_RST;
          end
        end
        default: begin
          r_state     <= PS_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_main_ctrl <= CTRL_RST;
          r_skid_ctrl <= CTRL_RST;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;

`ifdef PIPE_PERF_CNT_EN
  logic w_cnt_clr;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_cnt_clr   = !rstn;
  assign w_stall_inc = r_out_valid && !out_ready;
  assign w_flush_inc = flush && r_out_valid;

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .i_clr (w_cnt_clr),
    .i_inc (w_stall_inc),
    .o_cnt (stall_cnt)
  );

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .i_clr (w_cnt_clr),
    .i_inc (w_flush_inc),
    .o_cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a queue-based model.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CTRL_W-1:0] CTRL_RST = '0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } ent_t;

  logic              clk;
  logic              rstn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int   n_checks;
  int   n_fail;
  ent_t m_q[$];
  int   m_stall;
  int   m_flush;

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_RST (CTRL_RST),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // The stage behaves as a FIFO of depth 2 whose fill level gates acceptance.
  task automatic model_step(input logic v, input logic r, input logic f, input logic rs,
                            input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    int n;
    n = m_q.size();
    if (!rs) begin
      m_q.delete();
      m_stall = 0;
      m_flush = 0;
      return;
    end
    if (n > 0 && !r && m_stall < CNT_MAX) m_stall++;
    if (f) begin
      if (n > 0 && m_flush < CNT_MAX) m_flush++;
      m_q.delete();
      return;
    end
    if (n > 0 && r) void'(m_q.pop_front());
    if (v && n < 2) m_q.push_back('{d: d, c: c});
  endtask

  task automatic check_outputs(input string tag);
    logic exp_v;
    exp_v = (m_q.size() > 0);
    check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(exp_v));
    check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(m_q.size() < 2));
    if (exp_v) begin
      check_eq({tag, ".out_data"}, 64'(out_data), 64'(m_q[0].d));
      check_eq({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(m_q[0].c));
    end else begin
      check_eq({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(CTRL_RST));
    end
    check_eq({tag, ".stall_cnt"}, 64'(stall_cnt), PERF ? 64'(m_stall) : 64'(0));
    check_eq({tag, ".flush_cnt"}, 64'(flush_cnt), PERF ? 64'(m_flush) : 64'(0));
  endtask

  task automatic cycle(input string tag, input logic v, input logic r, input logic f,
                       input logic rs, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    rstn      = rs;
    flush     = f;
    in_valid  = v;
    out_ready = r;
    in_data   = d;
    in_ctrl   = c;
    @(posedge clk);
    model_step(v, r, f, rs, d, c);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_stall  = 0;
    m_flush  = 0;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    @(negedge clk);

    // Reset with garbage on the input side
    cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD, 16'hFFFF);
    cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'hBEEF, 16'hFFFF);
    check_eq("reset.out_ctrl0", 64'(out_ctrl), 64'h0);
    check_eq("reset.in_ready1", 64'(in_ready), 64'h1);

    // Streaming, one transfer per cycle
    for (int i = 1; i <= 8; i++) begin
      cycle("stream", 1'b1, 1'b1, 1'b0, 1'b1, DATA_W'(i), CTRL_W'(i));
      check_eq("stream.data", 64'(out_data), 64'(i));
      check_eq("stream.valid", 64'(out_valid), 64'h1);
    end
    cycle("drain", 1'b0, 1'b1, 1'b0, 1'b1, '0, '0);

    // Stall into the skid entry, then release
    cycle("skidA", 1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 16'h1);
    cycle("skidB", 1'b1, 1'b0, 1'b0, 1'b1, 32'hB, 16'h2);
    check_eq("skid.full_in_ready", 64'(in_ready), 64'h0);
    check_eq("skid.head_held", 64'(out_data), 64'hA);
    cycle("skidX", 1'b1, 1'b0, 1'b0, 1'b1, 32'hE, 16'h3);
    check_eq("skid.still_held", 64'(out_data), 64'hA);
    cycle("relA", 1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
    check_eq("rel.second", 64'(out_data), 64'hB);
    check_eq("rel.in_ready", 64'(in_ready), 64'h1);
    cycle("relB", 1'b0, 1'b1, 1'b0, 1'b1, '0, '0);

    // Flush while full, with a new entry offered in the same cycle
    cycle("fillA", 1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 16'h5);
    cycle("fillB", 1'b1, 1'b0, 1'b0, 1'b1, 32'h22, 16'h6);
    cycle("flushC", 1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 16'h7);
    check_eq("flush.valid", 64'(out_valid), 64'h0);
    check_eq("flush.ctrl", 64'(out_ctrl), 64'(CTRL_RST));
    check_eq("flush.cnt", 64'(flush_cnt), PERF ? 64'h1 : 64'h0);
    cycle("postflush", 1'b0, 1'b1, 1'b0, 1'b1, '0, '0);

    // Long stall to saturate the stall counter
    cycle("satload", 1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 16'h9);
    for (int i = 0; i < 20; i++) cycle("sat", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    check_eq("sat.stall_cnt", 64'(stall_cnt), PERF ? 64'(CNT_MAX) : 64'h0);
    cycle("sat2", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    check_eq("sat.stays", 64'(stall_cnt), PERF ? 64'(CNT_MAX) : 64'h0);

    // Random traffic, with a reset at the start and occasionally afterwards
    cycle("rreset", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 10000; i++) begin
      cycle("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 999) != 0,
            DATA_W'($urandom), CTRL_W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
